// File: rtl/audio_clk_gen.sv
// audio_clk_gen: multi-channel NCO clock generator with per-channel rise strobes and a lock monitor.
// Define AUDIO_CLK_GEN_SYNC_EN to add the cfg_sync all-channel realignment input.
module audio_clk_gen #(
  parameter int unsigned NUM_CLOCKS  = 2,
  parameter int unsigned ACC_W       = 24,
  parameter logic [31:0] DEFAULT_INC = 32'h000C_CCCD,
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_sel,
  input  logic [ACC_W-1:0]      cfg_inc,
  input  logic [ACC_W-1:0]      cfg_phase,
`ifdef AUDIO_CLK_GEN_SYNC_EN
  input  logic                  cfg_sync,
`endif
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int unsigned     CNT_W     = 16;
  localparam logic [ACC_W-1:0] INC_MAX  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] INC_RST  = DEFAULT_INC[ACC_W-1:0];
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic w_wr_ok;
  logic w_sync;
  logic w_restart;

  assign w_wr_ok = cfg_we && ({1'b0, cfg_sel} < 4'(NUM_CLOCKS));

`ifdef AUDIO_CLK_GEN_SYNC_EN
  assign w_sync = cfg_sync;
`else
  assign w_sync = 1'b0;
`endif

  assign w_restart = w_wr_ok || w_sync;

  // Per-channel phase accumulator; a reload (write or sync) masks the rise strobe.
  for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_ch
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_phase;
    logic [ACC_W-1:0] r_acc;
    logic             r_en;
    logic             w_load;
    logic [ACC_W-1:0] w_inc_eff;
    logic [ACC_W-1:0] w_acc_sum;

    assign w_load    = cfg_we && (cfg_sel == 3'(gi));
    assign w_inc_eff = (r_inc > INC_MAX) ? INC_MAX : r_inc;
    assign w_acc_sum = r_acc + w_inc_eff;

    always_ff @(posedge refclk) begin
      if (rst) begin
        r_inc   <= INC_RST;
        r_phase <= '0;
        r_acc   <= '0;
        r_en    <= 1'b0;
      end else if (w_load) begin
        r_inc   <= cfg_inc;
        r_phase <= cfg_phase;
        r_acc   <= cfg_phase;
        r_en    <= 1'b0;
      end else if (w_sync) begin
        r_acc   <= r_phase;
        r_en    <= 1'b0;
      end else begin
        r_acc   <= w_acc_sum;
        r_en    <= ~r_acc[ACC_W-1] & w_acc_sum[ACC_W-1];
      end
    end

    assign outclk[gi]    = r_acc[ACC_W-1];
    assign outclk_en[gi] = r_en;
  end

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= ST_SETTLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Settle counter restarts on every accepted reconfiguration, even while settling.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_restart) begin
      w_state_nxt = ST_SETTLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_cnt == LOCK_LAST) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          w_state_nxt = ST_LOCKED;
        end
        default: begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign locked = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_audio_clk_gen.sv
// Directed self-checking bench for audio_clk_gen (ACC_W=8, two channels, DEFAULT_INC=8'h20, LOCK_CYCLES=16).
module tb_audio_clk_gen;

  logic       refclk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_sel;
  logic [7:0] cfg_inc;
  logic [7:0] cfg_phase;
`ifdef AUDIO_CLK_GEN_SYNC_EN
  logic       cfg_sync;
`endif
  logic [1:0] outclk;
  logic [1:0] outclk_en;
  logic       locked;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         k;
  logic [1:0] ec;
  logic [1:0] ee;

  audio_clk_gen #(
    .NUM_CLOCKS (2),
    .ACC_W      (8),
    .DEFAULT_INC(32'h0000_0020),
    .LOCK_CYCLES(16)
  ) u_dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_inc  (cfg_inc),
    .cfg_phase(cfg_phase),
`ifdef AUDIO_CLK_GEN_SYNC_EN
    .cfg_sync (cfg_sync),
`endif
    .outclk   (outclk),
    .outclk_en(outclk_en),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Both channels at DEFAULT_INC from a shared zero phase: period 8, high for k%8 in 4..7.
  task automatic run_free(input string tag);
    for (int n = 1; n <= 16; n++) begin
      tick();
      ec = ((n % 8) >= 4) ? 2'b11 : 2'b00;
      ee = ((n % 8) == 4) ? 2'b11 : 2'b00;
      check($sformatf("%s_clk k=%0d", tag, n), 32'(outclk), 32'(ec));
      check($sformatf("%s_en k=%0d", tag, n), 32'(outclk_en), 32'(ee));
      check($sformatf("%s_lock k=%0d", tag, n), 32'(locked), 32'(n >= 16));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_sel   = 3'd0;
    cfg_inc   = 8'h00;
    cfg_phase = 8'h00;
`ifdef AUDIO_CLK_GEN_SYNC_EN
    cfg_sync  = 1'b0;
`endif

    tick();
    check("rst_clk", 32'(outclk), 32'd0);
    check("rst_en", 32'(outclk_en), 32'd0);
    check("rst_lock", 32'(locked), 32'd0);
    tick();
    rst = 1'b0;
    run_free("free");

    // Channel 1: inc 0x40, phase 0x80 -> high immediately, no strobe on the reload edge.
    cfg_we = 1'b1; cfg_sel = 3'd1; cfg_inc = 8'h40; cfg_phase = 8'h80;
    tick();
    cfg_we = 1'b0;
    check("wr1_clk", 32'(outclk), 32'b10);
    check("wr1_en", 32'(outclk_en), 32'b00);
    check("wr1_lock", 32'(locked), 32'd0);
    for (int j = 1; j <= 16; j++) begin
      tick();
      k  = 17 + j;
      ec = {((2 + j) % 4) >= 2, (k % 8) >= 4};
      ee = {(j % 4) == 0, (k % 8) == 4};
      check($sformatf("p4_clk j=%0d", j), 32'(outclk), 32'(ec));
      check($sformatf("p4_en j=%0d", j), 32'(outclk_en), 32'(ee));
      check($sformatf("p4_lock j=%0d", j), 32'(locked), 32'(j >= 16));
    end

    // Out-of-range select: nothing changes, lock is kept.
    cfg_we = 1'b1; cfg_sel = 3'd5; cfg_inc = 8'h00; cfg_phase = 8'h55;
    for (int j = 17; j <= 20; j++) begin
      tick();
      cfg_we = 1'b0;
      k  = 17 + j;
      ec = {((2 + j) % 4) >= 2, (k % 8) >= 4};
      ee = {(j % 4) == 0, (k % 8) == 4};
      check($sformatf("oor_clk j=%0d", j), 32'(outclk), 32'(ec));
      check($sformatf("oor_en j=%0d", j), 32'(outclk_en), 32'(ee));
      check($sformatf("oor_lock j=%0d", j), 32'(locked), 32'd1);
    end

    // Channel 0: inc 0x90 saturates to 0x80 -> toggles every cycle.
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_inc = 8'h90; cfg_phase = 8'h00;
    tick();
    cfg_we = 1'b0;
    check("sat_ld_clk", 32'(outclk), 32'b10);
    check("sat_ld_en", 32'(outclk_en), 32'b00);
    check("sat_ld_lock", 32'(locked), 32'd0);
    for (int m = 1; m <= 6; m++) begin
      ec = {((2 + 21 + m) % 4) >= 2, (m % 2) == 1};
      ee = {((21 + m) % 4) == 0, (m % 2) == 1};
      tick();
      check($sformatf("sat_clk m=%0d", m), 32'(outclk), 32'(ec));
      check($sformatf("sat_en m=%0d", m), 32'(outclk_en), 32'(ee));
    end

    // Channel 0: inc 0 stops it at phase 0xC0 (held high, no strobes).
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_inc = 8'h00; cfg_phase = 8'hC0;
    for (int m = 0; m <= 5; m++) begin
      tick();
      cfg_we = 1'b0;
      ec = {((2 + 28 + m) % 4) >= 2, 1'b1};
      ee = {((28 + m) % 4) == 0, 1'b0};
      check($sformatf("stop_clk m=%0d", m), 32'(outclk), 32'(ec));
      check($sformatf("stop_en m=%0d", m), 32'(outclk_en), 32'(ee));
      check($sformatf("stop_lock m=%0d", m), 32'(locked), 32'd0);
    end

    // Reset wins over a simultaneous write.
    rst = 1'b1;
    cfg_we = 1'b1; cfg_sel = 3'd1; cfg_inc = 8'h40; cfg_phase = 8'h80;
    tick();
    rst = 1'b0;
    cfg_we = 1'b0;
    check("rst2_clk", 32'(outclk), 32'd0);
    check("rst2_en", 32'(outclk_en), 32'd0);
    check("rst2_lock", 32'(locked), 32'd0);
    run_free("rerun");

`ifdef AUDIO_CLK_GEN_SYNC_EN
    // Offset channel 1 (phase 0) from channel 0, then realign both with sync.
    tick();
    tick();
    cfg_we = 1'b1; cfg_sel = 3'd1; cfg_inc = 8'h20; cfg_phase = 8'h00;
    tick();
    cfg_we = 1'b0;
    tick();
    tick();
    check("sync_pre_clk", 32'(outclk), 32'b01);
    cfg_sync = 1'b1;
    tick();
    cfg_sync = 1'b0;
    check("sync_clk", 32'(outclk), 32'b00);
    check("sync_en", 32'(outclk_en), 32'b00);
    check("sync_lock", 32'(locked), 32'd0);
    for (int m = 1; m <= 8; m++) begin
      tick();
      ec = ((m % 8) >= 4) ? 2'b11 : 2'b00;
      ee = ((m % 8) == 4) ? 2'b11 : 2'b00;
      check($sformatf("sync_run_clk m=%0d", m), 32'(outclk), 32'(ec));
      check($sformatf("sync_run_en m=%0d", m), 32'(outclk_en), 32'(ee));
    end
    cfg_sync = 1'b1;
    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_inc = 8'h20; cfg_phase = 8'h80;
    tick();
    cfg_sync = 1'b0;
    cfg_we = 1'b0;
    check("syncwr_clk", 32'(outclk), 32'b01);
    check("syncwr_en", 32'(outclk_en), 32'b00);
    tick();
    check("syncwr_next_clk", 32'(outclk), 32'b01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
